mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one byte-wide synchronous external memory between the CPU's instruction-fetch port and its data-access port. It serialises each 32-bit access into four byte cycles and generates the two stall signals consumed by the pipeline's stall controller. It sits between the CPU top (fetch address/valid, data valid/write/byte-enable/address/store data) and the board memory.

## Interface
- ADDR_W, 17, external byte-address width; request address bits above ADDR_W-1 are ignored.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_valid_i  in  1  fetch request.
- rom_addr_i  in  32  fetch byte address; bits [1:0] are ignored.
- rom_data_o  out  32  fetched instruction word.
- stall_rom_o  out  1  fetch not complete this cycle.
- ram_valid_i  in  1  data request.
- ram_write_i  in  1  1 = store, 0 = load.
- ram_byte_i  in  4  store byte enables; bit n enables byte n.
- ram_addr_i  in  32  data byte address; bits [1:0] are ignored.
- ram_wdata_i  in  32  store data, little-endian.
- ram_rdata_o  out  32  load data.
- stall_ram_o  out  1  data access not complete this cycle.
- ext_addr_o  out  ADDR_W  external byte address.
- ext_wdata_o  out  8  external write byte.
- ext_we_o  out  1  external write strobe.
- ext_rdata_i  in  8  external read byte; valid one cycle after its address.

## Operation
- States: IDLE, RD, WR, DONE. A 3-bit counter cnt is used by RD and WR. A 1-bit owner register records the requester: 0 = fetch, 1 = data.
- Requests are sampled only in IDLE.
  - ram_valid_i has priority over rom_valid_i. When both are set, data wins.
  - On grant, latch the word base {addr[ADDR_W-1:2],2'b00}, ram_write_i, ram_byte_i, ram_wdata_i and owner.
  - Go to WR for a data store. Go to RD for a fetch or a data load. Set cnt = 0.
- RD (cnt 0..4):
  - For cnt ≤ 3, drive ext_addr_o = base+cnt.
  - For cnt ≥ 1, capture ext_rdata_i into byte (cnt-1) of the assembly register.
  - At cnt = 4, go to DONE.
- WR (cnt 0..3):
  - Drive ext_addr_o = base+cnt and ext_wdata_o = wdata byte cnt.
  - ext_we_o = byte_enable[cnt]. Disabled bytes still take their cycle.
  - At cnt = 3, go to DONE.
- DONE (one cycle):
  - The owner's stall is low.
  - For a read, the assembled word is placed on rom_data_o or ram_rdata_o as selected by owner.
  - Then go to IDLE.
- Stall generation:
  - stall_rom_o = rom_valid_i & ~(state==DONE & owner==0).
  - stall_ram_o = ram_valid_i & ~(state==DONE & owner==1).
  - Both are forced to 0 while rst is high.
- ext_we_o, ext_addr_o and ext_wdata_o are registered. They are 0 in IDLE and DONE and outside active WR/RD cycles. ext_addr_o is held at its last value is also acceptable only in RD, and ext_we_o must be 0 everywhere except WR.
- Latched transaction fields are immune to input changes after the grant.
- If the requester drops valid mid-transaction, the transaction still completes and the DONE cycle is consumed silently.
- rom_data_o and ram_rdata_o hold their last value until the next completion of their own read. A store never changes ram_rdata_o.
- A fetch request that is still present after DONE, because the pipeline was held by the other stall, is re-serviced as a new fetch. This is functionally correct.

## Timing
- Read: the request is seen in IDLE at cycle 0. RD spans cycles 1–5 and DONE is cycle 6. The stall is high for cycles 0–5 and low in cycle 6.
- Write: IDLE at cycle 0, WR spans cycles 1–4 and DONE is cycle 5. The stall is high for cycles 0–4.
- Back-to-back: after DONE the state is IDLE. The next grant is therefore at the earliest two cycles after the previous grant cycle plus the transaction length. There is no bubble beyond the IDLE sampling cycle.
- The waiting requester's stall stays high across the other's whole transaction.
- Reset values: state IDLE, cnt 0, owner 0, ext_addr_o 0, ext_wdata_o 0, ext_we_o 0, rom_data_o 0, ram_rdata_o 0.
- Reset mid-transaction returns to IDLE on the next edge. ext_we_o is 0 from that edge on, and no partial word is delivered.

## Test plan
- Fetch only:
  - Stimulus: memory bytes 0x100..0x103 = 13,05,10,00; hold rom_valid_i with rom_addr_i = 0x100.
  - Required: stall_rom_o high for 6 cycles, then low for 1 cycle with rom_data_o = 0x00100513. ext_addr_o sequence is 0x100..0x103.
- Store with byte enables:
  - Stimulus: ram_write_i = 1, ram_byte_i = 4'b0101, ram_addr_i = 0x202, ram_wdata_i = 0xAABBCCDD.
  - Required: base address 0x200. ext_we_o pulses only at 0x200 (data DD) and 0x202 (data BB). stall_ram_o is low at cycle 5.
  - Follow-up: a load of 0x200 afterwards returns 0x??BB??DD, with the untouched bytes unchanged.
- Simultaneous requests:
  - Stimulus: fetch 0x0 and data load 0x40, both valid in the same IDLE cycle.
  - Required: the data load is served first and completes at cycle 6. The fetch is granted at cycle 7 and completes at cycle 13. stall_rom_o is high throughout cycles 0–12.
- Request change mid-flight:
  - Stimulus: change ram_addr_i at cycle 2 of a load of 0x300.
  - Required: ext_addr_o stays within 0x300..0x303 and the returned word comes from 0x300.
- Reset mid-write:
  - Stimulus: assert rst during WR cnt = 1.
  - Required: ext_we_o = 0 and state IDLE after the edge. Bytes 2–3 are not written. Both stalls are 0 while rst is high.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates a byte-wide synchronous external memory between the fetch and data ports,
// splitting each 32-bit access into four byte cycles and producing the pipeline stalls.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_valid_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              stall_rom_o,
    input  logic              ram_valid_i,
    input  logic              ram_write_i,
    input  logic [3:0]        ram_byte_i,
    input  logic [31:0]       ram_addr_i,
    input  logic [31:0]       ram_wdata_i,
    output logic [31:0]       ram_rdata_o,
    output logic              stall_ram_o,
    output logic [ADDR_W-1:0] ext_addr_o,
    output logic [7:0]        ext_wdata_o,
    output logic              ext_we_o,
    input  logic [7:0]        ext_rdata_i
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       rom_data_q, rom_data_d;
    logic [31:0]       ram_rdata_q, ram_rdata_d;
    logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
    logic [7:0]        ext_wdata_q, ext_wdata_d;
    logic              ext_we_q, ext_we_d;
    logic [31:0]       wdata_shift;

    // Word offset and address bits beyond the external space are dropped by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W], rom_addr_i[1:0],
                                ram_addr_i[31:ADDR_W], ram_addr_i[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        base_d      = base_q;
        asm_d       = asm_q;
        rom_data_d  = rom_data_q;
        ram_rdata_d = ram_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (ram_valid_i) begin
                    owner_d = 1'b1;
                    be_d    = ram_byte_i;
                    wdata_d = ram_wdata_i;
                    base_d  = {ram_addr_i[ADDR_W-1:2], 2'b00};
                    cnt_d   = 3'd0;
                    state_d = ram_write_i ? StWr : StRd;
                end else if (rom_valid_i) begin
                    owner_d = 1'b0;
                    base_d  = {rom_addr_i[ADDR_W-1:2], 2'b00};
                    cnt_d   = 3'd0;
                    state_d = StRd;
                end
            end
            StRd: begin
                // Read data lags its address by one cycle, so byte n lands at cnt n+1.
                cnt_d = cnt_q + 3'd1;
                case (cnt_q)
                    3'd1: asm_d[7:0]   = ext_rdata_i;
                    3'd2: asm_d[15:8]  = ext_rdata_i;
                    3'd3: asm_d[23:16] = ext_rdata_i;
                    3'd4: begin
                        if (owner_q) ram_rdata_d = {ext_rdata_i, asm_q};
                        else         rom_data_d  = {ext_rdata_i, asm_q};
                        cnt_d   = 3'd0;
                        state_d = StDone;
                    end
                    default: ;
                endcase
            end
            StWr: begin
                if (cnt_q == 3'd3) begin
                    cnt_d   = 3'd0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // External pins are registered, so they are derived from the next-state view.
    always_comb begin
        ext_addr_d  = '0;
        ext_wdata_d = 8'h00;
        ext_we_d    = 1'b0;
        wdata_shift = wdata_d >> {cnt_d[1:0], 3'b000};
        if ((state_d == StRd && cnt_d <= 3'd3) || state_d == StWr) begin
            ext_addr_d = {base_d[ADDR_W-1:2], cnt_d[1:0]};
        end
        if (state_d == StWr) begin
            ext_wdata_d = wdata_shift[7:0];
            ext_we_d    = be_d[cnt_d[1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            owner_q     <= 1'b0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            base_q      <= '0;
            asm_q       <= 24'h0;
            rom_data_q  <= 32'h0;
            ram_rdata_q <= 32'h0;
            ext_addr_q  <= '0;
            ext_wdata_q <= 8'h00;
            ext_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            base_q      <= base_d;
            asm_q       <= asm_d;
            rom_data_q  <= rom_data_d;
            ram_rdata_q <= ram_rdata_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_we_q    <= ext_we_d;
        end
    end

    assign rom_data_o  = rom_data_q;
    assign ram_rdata_o = ram_rdata_q;
    assign ext_addr_o  = ext_addr_q;
    assign ext_wdata_o = ext_wdata_q;
    assign ext_we_o    = ext_we_q;

    assign stall_rom_o = ~rst & rom_valid_i & ~(state_q == StDone && !owner_q);
    assign stall_ram_o = ~rst & ram_valid_i & ~(state_q == StDone && owner_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter against a 1 KiB synchronous byte memory model.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rom_valid_i = 1'b0;
    logic [31:0]       rom_addr_i = 32'h0;
    logic [31:0]       rom_data_o;
    logic              stall_rom_o;
    logic              ram_valid_i = 1'b0;
    logic              ram_write_i = 1'b0;
    logic [3:0]        ram_byte_i = 4'h0;
    logic [31:0]       ram_addr_i = 32'h0;
    logic [31:0]       ram_wdata_i = 32'h0;
    logic [31:0]       ram_rdata_o;
    logic              stall_ram_o;
    logic [ADDR_W-1:0] ext_addr_o;
    logic [7:0]        ext_wdata_o;
    logic              ext_we_o;
    logic [7:0]        ext_rdata_i = 8'h00;

    logic [7:0] mem [0:1023];
    logic       bd_we = 1'b0;
    logic [9:0] bd_addr = 10'h0;
    logic [7:0] bd_data = 8'h00;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_valid_i (rom_valid_i),
        .rom_addr_i  (rom_addr_i),
        .rom_data_o  (rom_data_o),
        .stall_rom_o (stall_rom_o),
        .ram_valid_i (ram_valid_i),
        .ram_write_i (ram_write_i),
        .ram_byte_i  (ram_byte_i),
        .ram_addr_i  (ram_addr_i),
        .ram_wdata_i (ram_wdata_i),
        .ram_rdata_o (ram_rdata_o),
        .stall_ram_o (stall_ram_o),
        .ext_addr_o  (ext_addr_o),
        .ext_wdata_o (ext_wdata_o),
        .ext_we_o    (ext_we_o),
        .ext_rdata_i (ext_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ext_we_o) mem[ext_addr_o[9:0]] <= ext_wdata_o;
        ext_rdata_i <= mem[ext_addr_o[9:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Read with fixed timing: stall high cycles 0-5, word visible in cycle 6.
    task automatic do_read(input string tag, input bit is_ram, input logic [31:0] addr,
                           input logic [31:0] exp, input int chg_cyc,
                           input logic [31:0] chg_addr);
        logic [31:0] base;
        logic        stall;
        base = {addr[31:2], 2'b00};
        @(negedge clk);
        if (is_ram) begin
            ram_valid_i = 1'b1;
            ram_write_i = 1'b0;
            ram_addr_i  = addr;
        end else begin
            rom_valid_i = 1'b1;
            rom_addr_i  = addr;
        end
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c == chg_cyc) begin
                if (is_ram) ram_addr_i = chg_addr;
                else        rom_addr_i = chg_addr;
            end
            #1;
            stall = is_ram ? stall_ram_o : stall_rom_o;
            check_eq({tag, "_stall"}, {31'b0, stall}, {31'b0, (c < 6)});
            check_eq({tag, "_we"}, {31'b0, ext_we_o}, 32'h0);
            if (c >= 1 && c <= 4)
                check_eq({tag, "_addr"}, {15'b0, ext_addr_o}, base + 32'(c - 1));
            if (c == 6)
                check_eq({tag, "_data"}, is_ram ? ram_rdata_o : rom_data_o, exp);
        end
        @(negedge clk);
        ram_valid_i = 1'b0;
        rom_valid_i = 1'b0;
    endtask

    initial begin
        // Reset state and forced-low stalls while rst is high.
        poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'h10); poke(10'h103, 8'h00);
        poke(10'h200, 8'h11); poke(10'h201, 8'h22); poke(10'h202, 8'h33); poke(10'h203, 8'h44);
        poke(10'h040, 8'h01); poke(10'h041, 8'h02); poke(10'h042, 8'h03); poke(10'h043, 8'h04);
        poke(10'h000, 8'hEF); poke(10'h001, 8'hBE); poke(10'h002, 8'hAD); poke(10'h003, 8'hDE);
        poke(10'h300, 8'hA1); poke(10'h301, 8'hB2); poke(10'h302, 8'hC3); poke(10'h303, 8'hD4);
        poke(10'h340, 8'h55); poke(10'h341, 8'h66); poke(10'h342, 8'h77); poke(10'h343, 8'h88);
        poke(10'h080, 8'h00); poke(10'h081, 8'h00); poke(10'h082, 8'h00); poke(10'h083, 8'h00);
        @(negedge clk);
        rom_valid_i = 1'b1;
        ram_valid_i = 1'b1;
        #1;
        check_eq("rst_stall_rom", {31'b0, stall_rom_o}, 32'h0);
        check_eq("rst_stall_ram", {31'b0, stall_ram_o}, 32'h0);
        check_eq("rst_ext_addr", {15'b0, ext_addr_o}, 32'h0);
        check_eq("rst_ext_wdata", {24'b0, ext_wdata_o}, 32'h0);
        check_eq("rst_ext_we", {31'b0, ext_we_o}, 32'h0);
        check_eq("rst_rom_data", rom_data_o, 32'h0);
        check_eq("rst_ram_rdata", ram_rdata_o, 32'h0);
        @(negedge clk);
        rom_valid_i = 1'b0;
        ram_valid_i = 1'b0;
        rst = 1'b0;

        do_read("fetch100", 1'b0, 32'h0000_0100, 32'h0010_0513, -1, 32'h0);

        // Store 0x202 with enables 0101; inputs are scrambled mid-flight.
        @(negedge clk);
        ram_valid_i = 1'b1;
        ram_write_i = 1'b1;
        ram_byte_i  = 4'b0101;
        ram_addr_i  = 32'h0000_0202;
        ram_wdata_i = 32'hAABB_CCDD;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 2) begin
                ram_wdata_i = 32'h1234_5678;
                ram_byte_i  = 4'b1111;
            end
            #1;
            check_eq("st_stall", {31'b0, stall_ram_o}, {31'b0, (c < 5)});
            case (c)
                1: begin
                    check_eq("st_we0", {31'b0, ext_we_o}, 32'h1);
                    check_eq("st_addr0", {15'b0, ext_addr_o}, 32'h200);
                    check_eq("st_data0", {24'b0, ext_wdata_o}, 32'hDD);
                end
                2: check_eq("st_we1", {31'b0, ext_we_o}, 32'h0);
                3: begin
                    check_eq("st_we2", {31'b0, ext_we_o}, 32'h1);
                    check_eq("st_addr2", {15'b0, ext_addr_o}, 32'h202);
                    check_eq("st_data2", {24'b0, ext_wdata_o}, 32'hBB);
                end
                4: check_eq("st_we3", {31'b0, ext_we_o}, 32'h0);
                5: begin
                    check_eq("st_we_done", {31'b0, ext_we_o}, 32'h0);
                    check_eq("st_rdata_kept", ram_rdata_o, 32'h0);
                end
                default: check_eq("st_we_idle", {31'b0, ext_we_o}, 32'h0);
            endcase
        end
        @(negedge clk);
        ram_valid_i = 1'b0;
        ram_write_i = 1'b0;
        check_eq("st_mem", {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]},
                 32'h44BB_22DD);
        do_read("ld200", 1'b1, 32'h0000_0200, 32'h44BB_22DD, -1, 32'h0);

        // Simultaneous fetch 0x0 and load 0x40: data first, fetch completes at cycle 13.
        @(negedge clk);
        rom_valid_i = 1'b1;
        rom_addr_i  = 32'h0;
        ram_valid_i = 1'b1;
        ram_write_i = 1'b0;
        ram_addr_i  = 32'h40;
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 7) ram_valid_i = 1'b0;
            #1;
            check_eq("both_stall_rom", {31'b0, stall_rom_o}, {31'b0, (c < 13)});
            if (c <= 6) check_eq("both_stall_ram", {31'b0, stall_ram_o}, {31'b0, (c < 6)});
            if (c == 1) check_eq("both_addr_first", {15'b0, ext_addr_o}, 32'h40);
            if (c == 6) begin
                check_eq("both_ram_data", ram_rdata_o, 32'h0403_0201);
                check_eq("both_rom_held", rom_data_o, 32'h0010_0513);
            end
            if (c == 10) check_eq("both_addr_fetch", {15'b0, ext_addr_o}, 32'h2);
            if (c == 13) check_eq("both_rom_data", rom_data_o, 32'hDEAD_BEEF);
        end
        @(negedge clk);
        rom_valid_i = 1'b0;

        do_read("ld300_chg", 1'b1, 32'h0000_0300, 32'hD4C3_B2A1, 2, 32'h0000_0340);

        // Reset asserted while the store is at byte 1.
        @(negedge clk);
        ram_valid_i = 1'b1;
        ram_write_i = 1'b1;
        ram_byte_i  = 4'b1111;
        ram_addr_i  = 32'h80;
        ram_wdata_i = 32'h8765_4321;
        @(negedge clk);
        #1;
        check_eq("rw_addr0", {15'b0, ext_addr_o}, 32'h80);
        @(negedge clk);
        rst = 1'b1;
        rom_valid_i = 1'b1;
        #1;
        check_eq("rw_addr1", {15'b0, ext_addr_o}, 32'h81);
        check_eq("rw_stall_rom", {31'b0, stall_rom_o}, 32'h0);
        check_eq("rw_stall_ram", {31'b0, stall_ram_o}, 32'h0);
        @(negedge clk);
        #1;
        check_eq("rw_we_after", {31'b0, ext_we_o}, 32'h0);
        check_eq("rw_addr_after", {15'b0, ext_addr_o}, 32'h0);
        check_eq("rw_ram_rdata", ram_rdata_o, 32'h0);
        check_eq("rw_rom_data", rom_data_o, 32'h0);
        rst = 1'b0;
        rom_valid_i = 1'b0;
        ram_valid_i = 1'b0;
        ram_write_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check_eq("rw_we_idle", {31'b0, ext_we_o}, 32'h0);
        end
        check_eq("rw_mem", {mem[10'h083], mem[10'h082], mem[10'h081], mem[10'h080]},
                 32'h0000_4321);
        do_read("post_rst", 1'b0, 32'h80, 32'h0000_4321, -1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
